// File: rtl/sha1_pkg.sv
// sha1_pkg: definitions shared by the SHA-1 message padder and the hash core.
//   WORD_W            schedule word width (shared with the hash core)
//   SHA1_PAD_MARKER   byte appended directly after the message
//   pad_state_t       padder control states
//   sha1_bswap        byte reversal of one word
//   sha1_total_words  padded length in 32-bit words for a byte count
package sha1_pkg;

  localparam int WORD_W = 32;
  localparam logic [7:0] SHA1_PAD_MARKER = 8'h80;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} pad_state_t;

  function automatic logic [WORD_W-1:0] sha1_bswap(input logic [WORD_W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // T = 16 * (floor((S + 8) / 64) + 1); the +8 is done in 33 bits so large
  // sizes do not wrap before the divide.
  function automatic logic [31:0] sha1_total_words(input logic [31:0] s);
    return 32'(((({1'b0, s} + 33'd8) >> 6) + 33'd1) << 4);
  endfunction

endpackage

// File: rtl/sha1_msg_pad_if.sv
// sha1_msg_pad_if: padded schedule-word stream.
//   valid  word is presented
//   ready  consumer accepts the word
//   data   big-endian padded word
//   index  word position 0..15 within the block
//   last   word belongs to the final block
// master = padder side, slave = hash core side.
interface sha1_msg_pad_if import sha1_pkg::*; ();
  logic              valid;
  logic              ready;
  logic [WORD_W-1:0] data;
  logic [3:0]        index;
  logic              last;

  modport master (output valid, data, index, last, input ready);
  modport slave  (input valid, data, index, last, output ready);
endinterface

// File: rtl/sha1_pad_word.sv
// sha1_pad_word: combinational formatter for one padded word.
//   k  word number within the padded message
//   s  message length in bytes
//   m  big-endian SRAM word for word k (ignored once k is past the message)
//   w  padded word: data, data+marker, marker, length high, length low or 0
module sha1_pad_word import sha1_pkg::*; (
  input  logic [31:0]       k,
  input  logic [31:0]       s,
  input  logic [WORD_W-1:0] m,
  output logic [WORD_W-1:0] w
);
  logic [33:0] base, s_x;
  logic [31:0] t;

  assign base = {k, 2'b00};
  assign s_x  = {2'b00, s};
  assign t    = sha1_total_words(s);

  always_comb begin
    w = '0;
    if (base + 34'd4 <= s_x) begin
      w = m;
    end else if (base < s_x) begin
      // 4k is word aligned, so the bytes left in this word are just s[1:0]
      case (s[1:0])
        2'd1:    w = {m[31:24], SHA1_PAD_MARKER, 16'h0000};
        2'd2:    w = {m[31:16], SHA1_PAD_MARKER, 8'h00};
        2'd3:    w = {m[31:8],  SHA1_PAD_MARKER};
        default: w = '0;
      endcase
    end else if (base == s_x) begin
      w = {SHA1_PAD_MARKER, 24'h000000};
    end else if (k == t - 32'd2) begin
      w = {29'b0, s[31:29]};
    end else if (k == t - 32'd1) begin
      w = {s[28:0], 3'b000};
    end
  end
endmodule

// File: rtl/sha1_msg_pad.sv
// sha1_msg_pad: reads a message from SRAM port A and streams the padded
// message as big-endian 32-bit schedule words, block after block.
//   clk, nreset       clock, synchronous active-low reset
//   start             pad request (taken only in IDLE)
//   message_addr/size byte address and byte length of the message
//   port_A_*          SRAM port A (read only; data one cycle after address)
//   w                 padded word stream (sha1_msg_pad_if.master)
//   busy, done        message in progress / one-cycle completion pulse
// Build option: SHA1_PAD_BSWAP_EN -- SRAM words are little-endian and are
// byte-swapped before formatting; otherwise they are used as read.
//
// Pipeline: A (address on port A) -> B (SRAM data, formatted) -> output reg.
// A B-stage word that cannot enter a stalled output lands in the skid
// register; A only advances when the skid is guaranteed free next cycle,
// and a held A simply re-reads the same address.
module sha1_msg_pad import sha1_pkg::*; #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  input  logic [31:0]       port_A_data_out,
  sha1_msg_pad_if.master    w,
  output logic              busy,
  output logic              done
);
  pad_state_t  state;
  logic [31:0] addr_q, size_q, t_q;
  logic        a_vld, b_vld, sk_vld;
  logic [31:0] a_k, b_k, sk_k, o_k;
  logic [WORD_W-1:0] sk_data, m, f;

  logic        out_take, sk_vld_n, adv, a_is_msg, nx_is_msg, hs_last, ld_vld;
  logic [31:0] a_k_nx, ld_k;
  logic [WORD_W-1:0] ld_data;
  logic [ADDR_W-1:0] rd_addr_nx;

  assign port_A_clk = clk;
  assign port_A_we  = 1'b0;

`ifdef SHA1_PAD_BSWAP_EN
  assign m = sha1_bswap(port_A_data_out);
`else
  assign m = port_A_data_out;
`endif

  sha1_pad_word u_fmt (.k(b_k), .s(size_q), .m(m), .w(f));

  // B and skid are never both occupied, so the skid fills only from B
  assign out_take   = !w.valid || w.ready;
  assign sk_vld_n   = sk_vld ? !out_take : (!out_take && b_vld);
  assign adv        = a_vld && !sk_vld_n;
  assign a_k_nx     = a_k + 32'd1;
  assign a_is_msg   = {a_k, 2'b00} < {2'b00, size_q};
  assign nx_is_msg  = {a_k_nx, 2'b00} < {2'b00, size_q};
  assign rd_addr_nx = ADDR_W'(addr_q + {a_k_nx[29:0], 2'b00});
  assign hs_last    = w.valid && w.ready && (o_k == t_q - 32'd1);
  assign ld_vld     = sk_vld || b_vld;
  assign ld_data    = sk_vld ? sk_data : f;
  assign ld_k       = sk_vld ? sk_k : b_k;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      t_q         <= '0;
      a_vld       <= 1'b0;
      a_k         <= '0;
      b_vld       <= 1'b0;
      b_k         <= '0;
      sk_vld      <= 1'b0;
      sk_k        <= '0;
      sk_data     <= '0;
      o_k         <= '0;
      port_A_addr <= '0;
      w.valid     <= 1'b0;
      w.data      <= '0;
      w.index     <= '0;
      w.last      <= 1'b0;
    end else begin
      b_vld <= adv;
      if (adv) begin
        b_k <= a_k;
        if (a_k_nx == t_q) begin
          a_vld <= 1'b0;
        end else begin
          a_k <= a_k_nx;
          // pad-only words leave the address untouched: no read for them
          if (nx_is_msg) port_A_addr <= rd_addr_nx;
        end
      end

      if (!sk_vld && !out_take && b_vld) begin
        sk_data <= f;
        sk_k    <= b_k;
      end
      sk_vld <= sk_vld_n;

      if (out_take) begin
        w.valid <= ld_vld;
        if (ld_vld) begin
          w.data  <= ld_data;
          w.index <= ld_k[3:0];
          w.last  <= ld_k >= t_q - 32'd16;
          o_k     <= ld_k;
        end
      end

      case (state)
        IDLE: if (start) begin
          state  <= RUN;
          busy   <= 1'b1;
          addr_q <= message_addr;
          size_q <= message_size;
          t_q    <= sha1_total_words(message_size);
          a_vld  <= 1'b1;
          a_k    <= '0;
          if (message_size != 32'd0) port_A_addr <= ADDR_W'(message_addr);
        end
        RUN, FLUSH: begin
          if (state == RUN && !a_is_msg) state <= FLUSH;
          if (hs_last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
